// File: rtl/parity_frame_tx.sv
// Framed serial transmitter: start, LSB-first data, parity, stop.
// Each bit is held for CLKS_PER_BIT clocks; tx comes straight from a flop.
module parity_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int ODD_PARITY   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              tx,
  output logic              busy,
  output logic              parity_out
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [CW-1:0]     cyc;
  logic [BW-1:0]     bitcnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_d;
  logic              tx_d;
  logic              par_d;
  logic              hs;
  logic              bit_end;

  assign hs      = valid_in & ready_out;
  assign bit_end = (cyc == CYC_LAST);
  assign par_d   = (ODD_PARITY != 0) ? ~^data_in : ^data_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:   if (hs) state_d = START;
      START:  if (bit_end) state_d = DATA;
      DATA:   if (bit_end && bitcnt == BIT_LAST)
                state_d = PARITY;
      PARITY: if (bit_end) state_d = STOP;
      STOP:   if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // tx is registered, so it is decoded from the state being entered
  always_comb begin
    ready_out = (state == IDLE);
    busy      = (state != IDLE);
    shreg_d   = shreg;
    if (hs)
      shreg_d = data_in;
    else if (state == DATA && bit_end)
      shreg_d = shreg >> 1;
    tx_d = 1'b1;
    unique case (1'b1)
      (state_d == START):  tx_d = 1'b0;
      (state_d == DATA):   tx_d = shreg_d[0];
      (state_d == PARITY): tx_d = parity_out;
      default:             tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx         <= 1'b1;
      parity_out <= 1'b0;
      shreg      <= '0;
      cyc        <= '0;
      bitcnt     <= '0;
    end else begin
      tx    <= tx_d;
      shreg <= shreg_d;
      if (hs) begin
        parity_out <= par_d;
        cyc        <= '0;
        bitcnt     <= '0;
      end else if (state != IDLE) begin
        cyc <= bit_end ? '0 : cyc + 1'b1;
        if (state == DATA && bit_end)
          bitcnt <= bitcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: three configurations checked against
// a frame model built from the word, parity rule and bit period.
module tb_parity_frame_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din   [3];
  logic       valid [3];
  logic       rdy   [3];
  logic       txv   [3];
  logic       bsy   [3];
  logic       par   [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  parity_frame_tx u0 (
    .clk(clk), .rst_n(rst_n), .data_in(din[0]),
    .valid_in(valid[0]), .ready_out(rdy[0]), .tx(txv[0]),
    .busy(bsy[0]), .parity_out(par[0])
  );

  parity_frame_tx #(
    .DATA_W(8), .CLKS_PER_BIT(3), .ODD_PARITY(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .data_in(din[1]),
    .valid_in(valid[1]), .ready_out(rdy[1]), .tx(txv[1]),
    .busy(bsy[1]), .parity_out(par[1])
  );

  parity_frame_tx #(
    .DATA_W(4), .CLKS_PER_BIT(1), .ODD_PARITY(0)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .data_in(din[2][3:0]),
    .valid_in(valid[2]), .ready_out(rdy[2]), .tx(txv[2]),
    .busy(bsy[2]), .parity_out(par[2])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int wof(input int u);
    return (u == 2) ? 4 : 8;
  endfunction

  function automatic int cof(input int u);
    case (u)
      0: return 16;
      1: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic bit oddof(input int u);
    return u == 1;
  endfunction

  // Expected serial bits of one frame, one entry per bit period
  function automatic void model(input int u, input logic [7:0] d,
                                output bit fr[$], output bit p);
    int ones = 0;
    fr = {};
    fr.push_back(1'b0);
    for (int k = 0; k < wof(u); k++) begin
      fr.push_back(d[k]);
      ones += int'(d[k]);
    end
    p = ((ones % 2) == 1) ^ oddof(u);
    fr.push_back(p);
    fr.push_back(1'b1);
  endfunction

  // Runs one frame on unit u; ends inside the first idle cycle.
  task automatic frame(input int u, input logic [7:0] d,
                       input bit pre, input bit hold,
                       input logic [7:0] nxt, input bit noisy);
    bit fr[$];
    bit p;
    int c;
    int total;
    int bcnt = 0;
    c = cof(u);
    model(u, d, fr, p);
    total = fr.size() * c;
    if (!pre) begin
      chk($sformatf("u%0d ready_pre", u), 32'(rdy[u]), 1);
      din[u] = d;
      valid[u] = 1'b1;
      @(posedge clk);
      #1;
    end
    valid[u] = hold;
    if (hold) din[u] = nxt;
    chk($sformatf("u%0d start_tx", u), 32'(txv[u]), 0);
    chk($sformatf("u%0d start_rdy", u), 32'(rdy[u]), 0);
    for (int t = 0; t < total; t++) begin
      if (bsy[u]) bcnt++;
      if (t % c == c / 2)
        chk($sformatf("u%0d bit%0d d%0h", u, t / c, d),
            32'(txv[u]), 32'(fr[t / c]));
      if (noisy && t < total - 1) begin
        valid[u] = 1'($urandom);
        din[u] = 8'($urandom);
      end else if (noisy) begin
        valid[u] = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    chk($sformatf("u%0d busy_len", u), bcnt, total);
    chk($sformatf("u%0d idle_busy", u), 32'(bsy[u]), 0);
    chk($sformatf("u%0d idle_rdy", u), 32'(rdy[u]), 1);
    chk($sformatf("u%0d idle_tx", u), 32'(txv[u]), 1);
    chk($sformatf("u%0d parity", u), 32'(par[u]), 32'(p));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      din[i] = '0;
      valid[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst u%0d tx", i), 32'(txv[i]), 1);
      chk($sformatf("rst u%0d rdy", i), 32'(rdy[i]), 1);
      chk($sformatf("rst u%0d busy", i), 32'(bsy[i]), 0);
      chk($sformatf("rst u%0d par", i), 32'(par[i]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(posedge clk);
      #1;
      if (t % 10 == 9) begin
        chk("idle tx", 32'(txv[0]), 1);
        chk("idle busy", 32'(bsy[0]), 0);
        chk("idle rdy", 32'(rdy[0]), 1);
      end
    end

    frame(0, 8'hA5, 0, 0, 8'h00, 0);
    frame(0, 8'h07, 0, 0, 8'h00, 0);
    frame(0, 8'h00, 0, 0, 8'h00, 0);
    frame(1, 8'h07, 0, 0, 8'h00, 0);
    frame(1, 8'h00, 0, 0, 8'h00, 0);
    frame(2, 8'h0B, 0, 0, 8'h00, 0);

    // input activity during a frame must not disturb it
    frame(0, 8'h5E, 0, 0, 8'h00, 1);
    @(posedge clk);
    #1;
    chk("no extra frame", 32'(bsy[0]), 0);

    // valid held high: next start 177 cycles after the first
    frame(0, 8'h96, 0, 1, 8'h4D, 0);
    @(posedge clk);
    #1;
    chk("b2b restart busy", 32'(bsy[0]), 1);
    frame(0, 8'h4D, 1, 0, 8'h00, 0);

    // reset during data bit 3
    din[0] = 8'hC3;
    valid[0] = 1'b1;
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    repeat (72) @(posedge clk);
    #1;
    chk("mid busy", 32'(bsy[0]), 1);
    chk("mid bit3", 32'(txv[0]), 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort tx", 32'(txv[0]), 1);
    chk("abort busy", 32'(bsy[0]), 0);
    chk("abort rdy", 32'(rdy[0]), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    frame(0, 8'h3C, 0, 0, 8'h00, 0);

    for (int i = 0; i < 4; i++) begin
      frame(0, 8'($urandom), 0, 0, 8'h00, i[0]);
      frame(1, 8'($urandom), 0, 0, 8'h00, 1);
      frame(2, 8'($urandom), 0, 0, 8'h00, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
